rr_slave_port: RTL and testbench

Slave-side port stage that sits directly downstream of the 4-master round-robin arbiter. It uses the arbiter's one-hot grant to select one master's request and registers it onto a single valid/ready slave interface. It tracks the issuing master of every outstanding read in an owner FIFO, so read data returns to the correct master even after the grant has moved on.

---
 rtl/rr_slave_port_if.sv | 36 +++
 rtl/rr_slave_port.sv | 131 +++++++++++++
 tb/tb_rr_slave_port.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/rr_slave_port_if.sv
// Bundle of the four-master request side, the single slave side and the error flags
// that surround the rr_slave_port stage.
interface rr_slave_port_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic [3:0]      gnt;
  logic [3:0]      m_valid;
  logic [3:0]      m_we;
  logic [4*AW-1:0] m_addr;
  logic [4*DW-1:0] m_wdata;
  logic [3:0]      m_ready;
  logic [3:0]      m_rvalid;
  logic [DW-1:0]   m_rdata;
  logic            s_valid;
  logic            s_we;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic            s_ready;
  logic            s_rvalid;
  logic [DW-1:0]   s_rdata;
  logic            gnt_err;
  logic            rsp_err;

  // The port stage itself
  modport slave (
    input  gnt, m_valid, m_we, m_addr, m_wdata, s_ready, s_rvalid, s_rdata,
    output m_ready, m_rvalid, m_rdata, s_valid, s_we, s_addr, s_wdata, gnt_err, rsp_err
  );

  // Arbiter, masters and downstream slave as seen from outside the stage
  modport master (
    output gnt, m_valid, m_we, m_addr, m_wdata, s_ready, s_rvalid, s_rdata,
    input  m_ready, m_rvalid, m_rdata, s_valid, s_we, s_addr, s_wdata, gnt_err, rsp_err
  );
endinterface

// File: rtl/rr_slave_port.sv
// Grant-selected request register onto one slave port, with an owner FIFO that routes
// in-order read responses back to the master that issued each read.
module rr_slave_port #(
  parameter int AW   = 4,
  parameter int DW   = 8,
  parameter int OSTD = 4
) (
  input logic          clk,
  input logic          rst,
  rr_slave_port_if.slave bus
);
  localparam int PW = $clog2(OSTD);
  localparam int CW = PW + 1;

  logic            s_valid_q, s_valid_d;
  logic            s_we_q, s_we_d;
  logic [AW-1:0]   s_addr_q, s_addr_d;
  logic [DW-1:0]   s_wdata_q, s_wdata_d;
  logic [1:0]      s_own_q, s_own_d;
  logic [3:0]      m_rvalid_q, m_rvalid_d;
  logic [DW-1:0]   m_rdata_q, m_rdata_d;
  logic            gnt_err_q, gnt_err_d;
  logic            rsp_err_q, rsp_err_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [1:0]      own_mem [OSTD];

  logic            onehot;
  logic [1:0]      sel;
  logic            slot_free;
  logic [CW-1:0]   ost;
  logic            rd_ok;
  logic [3:0]      m_ready;
  logic            accept;
  logic            push;
  logic            pop;
  logic [1:0]      head;

  // Grant decode and ready generation
  always_comb begin
    onehot = (bus.gnt != 4'd0) && ((bus.gnt & (bus.gnt - 4'd1)) == 4'd0);
    sel    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (bus.gnt[i]) sel = 2'(i);
    end
    slot_free = !s_valid_q || bus.s_ready;
    // A pop in this same cycle is deliberately not credited, keeping m_ready off s_rvalid
    ost   = cnt_q + CW'(s_valid_q && !s_we_q);
    rd_ok = (ost < CW'(OSTD));
    for (int i = 0; i < 4; i++) begin
      m_ready[i] = bus.gnt[i] && onehot && slot_free && (bus.m_we[i] || rd_ok);
    end
    accept = bus.m_valid[sel] && m_ready[sel];
  end

  // Output register and owner FIFO bookkeeping
  always_comb begin
    s_valid_d = s_valid_q;
    s_we_d    = s_we_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_own_d   = s_own_q;
    if (accept) begin
      s_valid_d = 1'b1;
      s_we_d    = bus.m_we[sel];
      s_addr_d  = bus.m_addr[sel*AW +: AW];
      s_wdata_d = bus.m_wdata[sel*DW +: DW];
      s_own_d   = sel;
    end else if (s_valid_q && bus.s_ready) begin
      s_valid_d = 1'b0;
    end

    push     = s_valid_q && bus.s_ready && !s_we_q;
    pop      = bus.s_rvalid && (cnt_q != '0);
    head     = own_mem[rd_ptr_q];
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);

    m_rvalid_d = pop ? (4'b0001 << head) : 4'b0000;
    m_rdata_d  = pop ? bus.s_rdata : m_rdata_q;
    gnt_err_d  = (bus.gnt != 4'd0) && !onehot;
    rsp_err_d  = rsp_err_q || (bus.s_rvalid && (cnt_q == '0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_valid_q  <= 1'b0;
      s_we_q     <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_own_q    <= 2'd0;
      m_rvalid_q <= 4'd0;
      m_rdata_q  <= '0;
      gnt_err_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      s_valid_q  <= s_valid_d;
      s_we_q     <= s_we_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      s_own_q    <= s_own_d;
      m_rvalid_q <= m_rvalid_d;
      m_rdata_q  <= m_rdata_d;
      gnt_err_q  <= gnt_err_d;
      rsp_err_q  <= rsp_err_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Entry storage needs no reset: the pointers and count define what is valid
  always_ff @(posedge clk) begin
    if (push) own_mem[wr_ptr_q] <= s_own_q;
  end

  assign bus.m_ready  = m_ready;
  assign bus.m_rvalid = m_rvalid_q;
  assign bus.m_rdata  = m_rdata_q;
  assign bus.s_valid  = s_valid_q;
  assign bus.s_we     = s_we_q;
  assign bus.s_addr   = s_addr_q;
  assign bus.s_wdata  = s_wdata_q;
  assign bus.gnt_err  = gnt_err_q;
  assign bus.rsp_err  = rsp_err_q;
endmodule

// File: tb/tb_rr_slave_port.sv
// Directed bench for rr_slave_port: writes, interleaved reads, outstanding limit,
// backpressure, grant/response errors and mid-operation reset.
module tb_rr_slave_port;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rr_slave_port_if #(.AW(4), .DW(8)) bus ();

  rr_slave_port #(.AW(4), .DW(8), .OSTD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.gnt     = 4'd0;
    bus.m_valid = 4'd0;
    bus.m_we    = 4'd0;
  endtask

  initial begin
    idle();
    bus.m_addr   = '0;
    bus.m_wdata  = '0;
    bus.s_ready  = 1'b0;
    bus.s_rvalid = 1'b0;
    bus.s_rdata  = '0;
    #1;
    chk("rst_s_valid", bus.s_valid, 0);
    chk("rst_m_rvalid", bus.m_rvalid, 0);
    chk("rst_gnt_err", bus.gnt_err, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_m_ready", bus.m_ready, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Single write from master 1
    bus.s_ready = 1'b1;
    bus.gnt = 4'b0010; bus.m_valid = 4'b0010; bus.m_we = 4'b0010;
    bus.m_addr = 16'h00A0; bus.m_wdata = 32'h00005C00;
    #1 chk("wr_m_ready", bus.m_ready, 4'b0010);
    tick();
    idle();
    chk("wr_s_valid", bus.s_valid, 1);
    chk("wr_s_we", bus.s_we, 1);
    chk("wr_s_addr", bus.s_addr, 4'hA);
    chk("wr_s_wdata", bus.s_wdata, 8'h5C);
    tick();
    chk("wr_drain", bus.s_valid, 0);

    // Read from master 0, then master 3
    bus.gnt = 4'b0001; bus.m_valid = 4'b0001; bus.m_we = 4'b0000;
    bus.m_addr = 16'h3001;
    #1 chk("rd0_m_ready", bus.m_ready, 4'b0001);
    tick();
    chk("rd0_s_addr", bus.s_addr, 4'h1);
    chk("rd0_s_we", bus.s_we, 0);
    bus.gnt = 4'b1000; bus.m_valid = 4'b1000;
    #1 chk("rd3_m_ready", bus.m_ready, 4'b1000);
    tick();
    chk("rd3_s_addr", bus.s_addr, 4'h3);
    idle();
    tick();
    chk("rd_drain", bus.s_valid, 0);
    bus.s_rvalid = 1'b1; bus.s_rdata = 8'h11;
    tick();
    bus.s_rvalid = 1'b0;
    chk("rsp0_m_rvalid", bus.m_rvalid, 4'b0001);
    chk("rsp0_m_rdata", bus.m_rdata, 8'h11);
    tick();
    chk("rsp0_pulse", bus.m_rvalid, 0);
    tick();
    bus.s_rvalid = 1'b1; bus.s_rdata = 8'h33;
    tick();
    bus.s_rvalid = 1'b0;
    chk("rsp3_m_rvalid", bus.m_rvalid, 4'b1000);
    chk("rsp3_m_rdata", bus.m_rdata, 8'h33);
    chk("rsp_no_err", bus.rsp_err, 0);

    // Outstanding limit with master 2
    bus.gnt = 4'b0100; bus.m_valid = 4'b0100; bus.m_we = 4'b0000;
    bus.m_addr = 16'h0500;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("ost_rd%0d_ready", i), bus.m_ready, 4'b0100);
      tick();
    end
    chk("ost_5th_blocked", bus.m_ready, 0);
    tick();
    chk("ost_full_blocked", bus.m_ready, 0);
    bus.m_we = 4'b0100; bus.m_wdata = 32'h00770000;
    #1 chk("ost_wr_ready", bus.m_ready, 4'b0100);
    tick();
    chk("ost_wr_s_we", bus.s_we, 1);
    chk("ost_wr_s_wdata", bus.s_wdata, 8'h77);
    bus.m_we = 4'b0000;
    bus.s_rvalid = 1'b1; bus.s_rdata = 8'h44;
    #1 chk("ost_no_same_cycle_credit", bus.m_ready, 0);
    tick();
    bus.s_rvalid = 1'b0;
    chk("ost_pop_m_rvalid", bus.m_rvalid, 4'b0100);
    chk("ost_pop_m_rdata", bus.m_rdata, 8'h44);
    #1 chk("ost_after_pop_ready", bus.m_ready, 4'b0100);
    tick();
    idle();
    chk("ost_rd_accepted", bus.s_valid, 1);
    chk("ost_rd_s_we", bus.s_we, 0);
    tick();
    bus.s_rvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("ost_drain%0d_m_rvalid", i), bus.m_rvalid, 4'b0100);
    end
    bus.s_rvalid = 1'b0;
    tick();
    chk("ost_drained_err", bus.rsp_err, 0);

    // Backpressure with a write from master 0
    bus.gnt = 4'b0001; bus.m_valid = 4'b0001; bus.m_we = 4'b0001;
    bus.m_addr = 16'h0007; bus.m_wdata = 32'h000000E1;
    tick();
    bus.s_ready = 1'b0;
    bus.m_addr = 16'h0008; bus.m_wdata = 32'h00000022;
    #1 chk("bp_m_ready", bus.m_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp%0d_s_addr", i), bus.s_addr, 4'h7);
      chk($sformatf("bp%0d_s_wdata", i), bus.s_wdata, 8'hE1);
      chk($sformatf("bp%0d_m_ready", i), bus.m_ready, 0);
    end
    bus.s_ready = 1'b1;
    #1 chk("bp_release_ready", bus.m_ready, 4'b0001);
    tick();
    idle();
    chk("bp_next_s_addr", bus.s_addr, 4'h8);
    chk("bp_next_s_wdata", bus.s_wdata, 8'h22);
    tick();

    // Malformed grant and stray response
    bus.gnt = 4'b0110; bus.m_valid = 4'b0110; bus.m_we = 4'b0110;
    #1 chk("err_m_ready", bus.m_ready, 0);
    tick();
    idle();
    chk("err_gnt_err", bus.gnt_err, 1);
    chk("err_no_accept", bus.s_valid, 0);
    tick();
    chk("err_gnt_err_clr", bus.gnt_err, 0);
    bus.s_rvalid = 1'b1; bus.s_rdata = 8'hAA;
    tick();
    bus.s_rvalid = 1'b0;
    chk("err_rsp_err", bus.rsp_err, 1);
    chk("err_no_rvalid", bus.m_rvalid, 0);
    tick();
    tick();
    chk("err_rsp_sticky", bus.rsp_err, 1);

    // Reset with two reads outstanding and one held in the register
    bus.gnt = 4'b0001; bus.m_valid = 4'b0001; bus.m_we = 4'b0000;
    bus.m_addr = 16'h0009;
    tick();
    tick();
    idle();
    bus.s_ready = 1'b0;
    chk("mr_s_valid_pre", bus.s_valid, 1);
    rst = 1'b0;
    #1;
    chk("mr_s_valid", bus.s_valid, 0);
    chk("mr_s_addr", bus.s_addr, 0);
    chk("mr_m_rdata", bus.m_rdata, 0);
    chk("mr_rsp_err", bus.rsp_err, 0);
    chk("mr_m_rvalid", bus.m_rvalid, 0);
    tick();
    rst = 1'b1;
    bus.s_ready = 1'b1;
    tick();
    bus.s_rvalid = 1'b1; bus.s_rdata = 8'h5A;
    tick();
    bus.s_rvalid = 1'b0;
    chk("mr_late_rsp_err", bus.rsp_err, 1);
    chk("mr_late_no_rvalid", bus.m_rvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
